// File: rtl/ram_initiator.sv
// Host-side burst initiator for the 5-byte data RAM port.
// Optional write read-back check: define RAM_INITIATOR_VERIFY_EN.
module ram_initiator #(
  parameter int MEM_DEPTH = 5,
  parameter int RO_ADDR   = 0
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [2:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       done,
  output logic       err,
  output logic       nw,
  output logic [2:0] addr1,
  output logic [7:0] Wdata_ram,
  input  logic [7:0] Rdata1
);

`ifdef RAM_INITIATOR_VERIFY_EN
  typedef enum logic [1:0] {
    IDLE, WRITE, READ, VERIFY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, WRITE, READ
  } state_t;
`endif

  localparam logic [2:0] LAST = 3'(MEM_DEPTH - 1);
  localparam logic [2:0] RO   = 3'(RO_ADDR);

  state_t     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_last_q, rsp_last_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
`ifdef RAM_INITIATOR_VERIFY_EN
  logic [2:0] start_q, start_d;
  logic [2:0] len_q, len_d;
`endif

  logic       accept;
  logic       illegal;
  logic       is_ro;
  logic [2:0] addr_nx;

  assign req_ready = (state_q == IDLE) && !rsp_valid_q;
  assign accept    = req_valid && req_ready;
  assign illegal   = int'(req_addr) >= MEM_DEPTH;
  assign is_ro     = addr_q == RO;
  assign addr_nx   = (addr_q == LAST) ? 3'd0 : addr_q + 3'd1;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef RAM_INITIATOR_VERIFY_EN
    start_d     = start_q;
    len_d       = len_q;
`endif
    nw          = 1'b1;
    addr1       = 3'd0;
    Wdata_ram   = 8'd0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          wdata_d = req_wdata;
          err_d   = 1'b0;
`ifdef RAM_INITIATOR_VERIFY_EN
          start_d = req_addr;
          len_d   = req_len;
`endif
          if (illegal) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = req_write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        addr1     = addr_q;
        Wdata_ram = wdata_q;
        // The RAM owns the input-mapped byte, so that beat is dropped.
        nw        = is_ro;
        if (is_ro) err_d = 1'b1;
        addr_d = addr_nx;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
`ifdef RAM_INITIATOR_VERIFY_EN
          state_d = VERIFY;
          addr_d  = start_q;
          cnt_d   = len_q;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      READ: begin
        addr1 = addr_q;
        if (rsp_valid_q && rsp_last_q) begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end else if (!rsp_valid_q || rsp_ready) begin
          rsp_data_d  = Rdata1;
          rsp_valid_d = 1'b1;
          rsp_last_d  = cnt_q == 3'd0;
          addr_d      = addr_nx;
          cnt_d       = cnt_q - 3'd1;
        end
      end
`ifdef RAM_INITIATOR_VERIFY_EN
      VERIFY: begin
        addr1 = addr_q;
        if (!is_ro && Rdata1 != wdata_q) err_d = 1'b1;
        addr_d = addr_nx;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      addr_q      <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef RAM_INITIATOR_VERIFY_EN
      start_q     <= 3'd0;
      len_q       <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef RAM_INITIATOR_VERIFY_EN
      start_q     <= start_d;
      len_q       <= len_d;
`endif
    end
  end

endmodule
